// File: rtl/tribuf_frame_reader.sv
// Read-side client of the triple-buffer controller: fetches one granted frame as
// bursts and streams it out. Define FRAME_RD_STATS_EN to add frame/stall counters.
module tribuf_frame_reader #(
  parameter int unsigned BEAT_BYTES      = 8,
  parameter int unsigned BURST_BEATS     = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    fclk,
  input  logic                    rst_n,
  input  logic                    vsync_req,
  output logic                    frame_sync,
  output logic                    frame_ready,
  input  logic                    frame_valid,
  input  logic                    frame_done,
  input  logic [31:0]             FRAME_BYTES,
  input  logic [31:0]             BUF_ADDR,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  output logic [7:0]              mem_req_len,
  input  logic                    mem_rd_valid,
  output logic                    mem_rd_ready,
  input  logic [8*BEAT_BYTES-1:0] mem_rd_data,
  input  logic                    mem_rd_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*BEAT_BYTES-1:0] out_data,
  output logic                    out_sof,
`ifdef FRAME_RD_STATS_EN
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_stall,
`endif
  output logic                    busy
);

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, DRAIN, COMPLETE} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] total_q, total_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] left_q, left_d;
  logic [31:0] rcv_q, rcv_d;
  logic [3:0]  outst_q, outst_d;

  logic        active;
  logic        req_fire;
  logic        beat_acc;
  logic        last_acc;
  logic [31:0] chunk;
  logic [31:0] grant_beats;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    total_d     = total_q;
    issued_d    = issued_q;
    left_d      = left_q;
    rcv_d       = rcv_q;
    outst_d     = outst_q;
    grant_beats = FRAME_BYTES >> BEAT_SHIFT;

    active        = (state_q == ISSUE) || (state_q == DRAIN);
    busy          = (state_q != IDLE);
    frame_sync    = (state_q == IDLE) && vsync_req;
    frame_ready   = (state_q == IDLE) || (state_q == COMPLETE);

    // Request fields derive only from registers, so they hold while stalled.
    chunk         = (left_q < BURST_BEATS) ? left_q : BURST_BEATS;
    mem_req_addr  = base_q + (issued_q << BEAT_SHIFT);
    mem_req_len   = (left_q == '0) ? '0 : 8'(chunk - 32'd1);
    mem_req_valid = (state_q == ISSUE) && (outst_q < 4'(MAX_OUTSTANDING)) && (left_q != '0);
    req_fire      = mem_req_valid && mem_req_ready;

    out_valid     = active && mem_rd_valid;
    mem_rd_ready  = active ? out_ready : 1'b1;
    out_data      = mem_rd_data;
    out_sof       = out_valid && (rcv_q == '0);
    beat_acc      = out_valid && out_ready;
    last_acc      = beat_acc && mem_rd_last;

    if (req_fire) begin
      left_d   = left_q - chunk;
      issued_d = issued_q + chunk;
    end
    if (beat_acc) begin
      rcv_d = rcv_q + 32'd1;
    end
    if (req_fire && !last_acc) begin
      outst_d = outst_q + 4'd1;
    end else if (!req_fire && last_acc) begin
      outst_d = outst_q - 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_valid) state_d = GRANT;
      end
      GRANT: begin
        base_d   = BUF_ADDR;
        total_d  = grant_beats;
        left_d   = grant_beats;
        issued_d = '0;
        rcv_d    = '0;
        outst_d  = '0;
        state_d  = (grant_beats == '0) ? COMPLETE : ISSUE;
      end
      ISSUE: begin
        if (left_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if ((rcv_q == total_q) && (outst_q == '0)) state_d = COMPLETE;
      end
      COMPLETE: begin
        if (frame_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      total_q  <= '0;
      issued_q <= '0;
      left_q   <= '0;
      rcv_q    <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      left_q   <= left_d;
      rcv_q    <= rcv_d;
      outst_q  <= outst_d;
    end
  end

`ifdef FRAME_RD_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_stall_d  = stat_stall_q;
    if ((state_q == COMPLETE) && frame_done) stat_frames_d = stat_frames_q + 32'd1;
    if (out_valid && !out_ready)             stat_stall_d  = stat_stall_q + 32'd1;
    stat_frames = stat_frames_q;
    stat_stall  = stat_stall_q;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_tribuf_frame_reader.sv
// Scoreboard bench for tribuf_frame_reader: a frame model queues expected requests
// and beats; a negedge monitor pops and compares whatever the DUT presents.
module tb_tribuf_frame_reader;
  localparam int unsigned BB = 8;
  localparam int unsigned BL = 16;

  typedef struct { logic [31:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [63:0] data; logic sof; } beat_t;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_req = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_done = 1'b0;
  logic [31:0] FRAME_BYTES = '0;
  logic [31:0] BUF_ADDR = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rd_valid = 1'b0;
  logic [63:0] mem_rd_data = '0;
  logic        mem_rd_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        frame_sync, frame_ready, mem_req_valid, mem_rd_ready;
  logic        out_valid, out_sof, busy;
  logic [31:0] mem_req_addr;
  logic [7:0]  mem_req_len;
  logic [63:0] out_data;

  int total = 0;
  int bad = 0;
  req_t  exp_req[$];
  beat_t exp_beat[$];
  req_t  mem_pend[$];
  int  req_mode = 1;     // 0 random, 1 always ready, 2 never ready
  int  ready_mode = 1;   // 0 random, 1 always, 2 toggle
  bit  data_en = 1'b1;
  bit  stale_chk = 1'b0;
  bit  rd_acc = 1'b0;
  int  req_fires = 0;
  int  rd_cnt = 0;

  tribuf_frame_reader #(.BEAT_BYTES(8), .BURST_BEATS(16), .MAX_OUTSTANDING(4)) dut (
    .fclk(fclk), .rst_n(rst_n), .vsync_req(vsync_req), .frame_sync(frame_sync),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_done(frame_done),
    .FRAME_BYTES(FRAME_BYTES), .BUF_ADDR(BUF_ADDR),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .busy(busy)
  );

  always #5 fclk = ~fclk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5C3_5A3C, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: split the frame into bursts of up to BL beats from the base.
  task automatic push_model(input logic [31:0] base, input logic [31:0] bytes);
    int unsigned beats;
    int unsigned done;
    int unsigned n;
    beats = bytes / BB;
    done  = 0;
    while (done < beats) begin
      n = (beats - done > BL) ? BL : beats - done;
      exp_req.push_back('{addr: base + 32'(done * BB), len: 8'(n - 1)});
      for (int unsigned k = 0; k < n; k++)
        exp_beat.push_back('{data: mem_word(base + 32'((done + k) * BB)), sof: (done + k == 0)});
      done += n;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    req_t  e;
    beat_t b;
    forever begin
      @(negedge fclk);
      if (mem_req_valid && mem_req_ready) begin
        req_fires++;
        mem_pend.push_back('{addr: mem_req_addr, len: mem_req_len});
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got addr %0h len %0d, expected none", mem_req_addr, mem_req_len);
        end else begin
          e = exp_req.pop_front();
          check("req_addr", 64'(mem_req_addr), 64'(e.addr));
          check("req_len", 64'(mem_req_len), 64'(e.len));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_beat.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %0h, expected none", out_data);
        end else begin
          b = exp_beat.pop_front();
          check("beat_data", out_data, b.data);
          check("beat_sof", 64'(out_sof), 64'(b.sof));
        end
      end
      if (out_valid) check("rd_ready_mirror", 64'(mem_rd_ready), 64'(out_ready));
      if (stale_chk && mem_rd_valid) begin
        check("stale_out_valid", 64'(out_valid), 64'd0);
        check("stale_rd_ready", 64'(mem_rd_ready), 64'd1);
      end
      if (mem_rd_valid && mem_rd_ready) rd_cnt++;
      rd_acc = mem_rd_valid && mem_rd_ready;
    end
  end

  // Memory responder: in-order bursts, random gaps, valid held until accepted.
  initial begin
    bit   act;
    bit   hold;
    bit   acc;
    req_t cur;
    int unsigned beat;
    act = 1'b0; beat = 0; cur = '{addr: '0, len: '0};
    forever begin
      @(posedge fclk); #1;
      acc    = rd_acc;
      rd_acc = 1'b0;
      hold   = mem_rd_valid && !acc;
      if (acc && act) begin
        if (beat == 32'(cur.len)) act = 1'b0;
        else beat++;
      end
      if (!act && data_en && mem_pend.size() > 0) begin
        cur  = mem_pend.pop_front();
        act  = 1'b1;
        beat = 0;
      end
      mem_rd_valid = act && (hold || (data_en && $urandom_range(0, 3) != 0));
      mem_rd_data  = mem_word(cur.addr + 32'(beat * BB));
      mem_rd_last  = act && (beat == 32'(cur.len));
    end
  end

  // Handshake drivers
  initial begin
    forever begin
      @(posedge fclk); #1;
      case (req_mode)
        0:       mem_req_ready = 1'($urandom_range(0, 1));
        1:       mem_req_ready = 1'b1;
        default: mem_req_ready = 1'b0;
      endcase
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  task automatic grant(input logic [31:0] base, input logic [31:0] bytes);
    @(posedge fclk); #1; vsync_req = 1'b1;
    @(negedge fclk);
    check("sync_idle", 64'(frame_sync), 64'd1);
    check("ready_idle", 64'(frame_ready), 64'd1);
    @(posedge fclk); #1;
    frame_valid = 1'b1; BUF_ADDR = 32'hDEAD_BEE8; FRAME_BYTES = 32'h0000_0800;
    push_model(base, bytes);
    @(posedge fclk); #1;
    frame_valid = 1'b0; BUF_ADDR = base; FRAME_BYTES = bytes;
    @(negedge fclk);
    check("sync_grant", 64'(frame_sync), 64'd0);
    check("ready_grant", 64'(frame_ready), 64'd0);
    @(posedge fclk); #1;
    vsync_req = 1'b0; BUF_ADDR = 32'hDEAD_BEE8; FRAME_BYTES = 32'h0000_0800;
  endtask

  task automatic wait_complete(input string name);
    int unsigned n;
    n = 0;
    do begin @(negedge fclk); n++; end while (!(busy && frame_ready) && n < 5000);
    check({name, "_complete"}, 64'(busy && frame_ready), 64'd1);
    check({name, "_beats_left"}, 64'(exp_beat.size()), 64'd0);
    check({name, "_reqs_left"}, 64'(exp_req.size()), 64'd0);
  endtask

  task automatic finish_frame(input string name);
    @(posedge fclk); #1; frame_done = 1'b1;
    @(posedge fclk); #1; frame_done = 1'b0;
    @(negedge fclk);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: sequence still running at %0t, required to finish earlier", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int f0;
    int r0;
    int unsigned n;

    repeat (3) @(posedge fclk);
    @(negedge fclk);
    check("rst_frame_ready", 64'(frame_ready), 64'd1);
    check("rst_frame_sync", 64'(frame_sync), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_req_len", 64'(mem_req_len), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #1 rst_n = 1'b1;

    // Basic 256-byte frame
    req_mode = 1; ready_mode = 1;
    f0 = req_fires;
    grant(32'h1000_0000, 256);
    wait_complete("f256");
    check("f256_req_count", 64'(req_fires - f0), 64'd2);
    check("f256_frame_ready", 64'(frame_ready), 64'd1);
    finish_frame("f256");

    // 200 bytes -> 25 beats
    req_mode = 0; ready_mode = 0;
    grant(32'h1000_4000, 200);
    wait_complete("f200");
    finish_frame("f200");

    // Request stall, then outstanding limit with no data returning
    data_en = 1'b0; req_mode = 2;
    grant(32'h2000_0000, 1024);
    n = 0;
    do begin @(negedge fclk); n++; end while (!mem_req_valid && n < 50);
    repeat (10) begin
      @(negedge fclk);
      check("stall_valid", 64'(mem_req_valid), 64'd1);
      check("stall_addr", 64'(mem_req_addr), 64'h2000_0000);
      check("stall_len", 64'(mem_req_len), 64'd15);
    end
    #1 f0 = req_fires; req_mode = 1;
    repeat (20) @(negedge fclk);
    #1;
    check("outst_req_count", 64'(req_fires - f0), 64'd4);
    check("outst_req_valid", 64'(mem_req_valid), 64'd0);
    data_en = 1'b1; req_mode = 0;
    wait_complete("outst");
    finish_frame("outst");

    // Toggling out_ready
    ready_mode = 2;
    grant({$urandom_range(0, 32'h0FFF_FFFF), 3'b000} & 32'hFFFF_FFF8, 512 + 8 * $urandom_range(0, 40));
    wait_complete("toggle");
    finish_frame("toggle");
    ready_mode = 0;

    // Zero-length frame
    f0 = req_fires;
    grant(32'h3000_0000, 0);
    wait_complete("zero");
    #1 check("zero_req_count", 64'(req_fires - f0), 64'd0);
    finish_frame("zero");

    // frame_done and frame_valid ignored while the frame is in flight
    data_en = 1'b0; req_mode = 1;
    grant(32'h4000_0000, 256);
    repeat (4) @(posedge fclk);
    #1 frame_done = 1'b1;
    @(posedge fclk); #1 frame_done = 1'b0;
    @(negedge fclk);
    check("early_done_busy", 64'(busy), 64'd1);
    check("early_done_ready", 64'(frame_ready), 64'd0);
    @(posedge fclk); #1 frame_valid = 1'b1; BUF_ADDR = 32'h5000_0000; FRAME_BYTES = 64;
    @(posedge fclk); #1 frame_valid = 1'b0;
    data_en = 1'b1; req_mode = 0;
    wait_complete("drain_ign");
    finish_frame("drain_ign");

    // Random frames, including one wrapping the 32-bit address space
    for (int i = 0; i < 4; i++) begin
      grant(32'($urandom) & 32'hFFFF_FFF8, $urandom_range(1, 1500));
      wait_complete("rand");
      finish_frame("rand");
    end
    grant(32'hFFFF_FF80, 512);
    wait_complete("wrap");
    finish_frame("wrap");

    // Reset in ISSUE with two bursts outstanding
    data_en = 1'b0; req_mode = 2;
    grant(32'h6000_0000, 1024);
    #1 f0 = req_fires; r0 = rd_cnt; req_mode = 1;
    n = 0;
    do begin @(negedge fclk); #1; n++; end while (req_fires - f0 < 2 && n < 100);
    req_mode = 2;
    check("rstmid_two_reqs", 64'(req_fires - f0), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_valid", 64'(mem_req_valid), 64'd0);
    check("rstmid_req_addr", 64'(mem_req_addr), 64'd0);
    check("rstmid_req_len", 64'(mem_req_len), 64'd0);
    check("rstmid_frame_ready", 64'(frame_ready), 64'd1);
    check("rstmid_busy", 64'(busy), 64'd0);
    exp_req.delete();
    exp_beat.delete();
    stale_chk = 1'b1; data_en = 1'b1;
    @(posedge fclk); #2 rst_n = 1'b1;
    n = 0;
    do begin @(negedge fclk); #1; n++; end while (rd_cnt - r0 < 32 && n < 2000);
    check("rstmid_stale_beats", 64'(rd_cnt - r0), 64'd32);
    stale_chk = 1'b0;
    req_mode = 0;
    grant(32'h7000_0040, 136);
    wait_complete("recover");
    finish_frame("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
